// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline definitions: state encoding, widths, stage-control bundle
`ifndef HAZARD_CTRL_PKG_SV
`define HAZARD_CTRL_PKG_SV

package hazard_ctrl_pkg;

  // Datapath widths shared across the pipeline
  localparam int OPCODE_W = 7;
  localparam int ALU_W    = 32;

  // Hazard FSM encoding (3-bit, kept stable for older tooling)
  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_LSTALL = 3'd2;
  localparam logic [2:0] ST_MWAIT  = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Stage control lines driven by the hazard controller
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic flush_d;
    logic flush_e;
    logic ce_m;
  } stage_ctrl_t;

  // Everything held and flushed, memory stage frozen
  localparam stage_ctrl_t CTRL_RESET =
    '{stall_f: 1'b1, stall_d: 1'b1, flush_d: 1'b1, flush_e: 1'b1, ce_m: 1'b0};
  // Front end held, memory stage frozen, nothing flushed
  localparam stage_ctrl_t CTRL_HOLD =
    '{stall_f: 1'b1, stall_d: 1'b1, flush_d: 1'b0, flush_e: 1'b0, ce_m: 1'b0};
  // Free-running pipeline
  localparam stage_ctrl_t CTRL_RUN =
    '{stall_f: 1'b0, stall_d: 1'b0, flush_d: 1'b0, flush_e: 1'b0, ce_m: 1'b1};
  // Data hazard: hold fetch/decode, inject a bubble into execute
  localparam stage_ctrl_t CTRL_BUBBLE =
    '{stall_f: 1'b1, stall_d: 1'b1, flush_d: 1'b0, flush_e: 1'b1, ce_m: 1'b1};
  // Redirect: squash the wrong-path instructions in decode and execute
  localparam stage_ctrl_t CTRL_FLUSH =
    '{stall_f: 1'b0, stall_d: 1'b0, flush_d: 1'b1, flush_e: 1'b1, ce_m: 1'b1};

endpackage

`endif

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational source/destination comparators for hazard_ctrl
module hazard_detect #(
  parameter int AWIDTH = 5
) (
  input  logic [AWIDTH-1:0] id_rs1,
  input  logic [AWIDTH-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [AWIDTH-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic [AWIDTH-1:0] mem_rd,
  input  logic              mem_we,
  output logic              load_use,
  output logic              raw_match
);

  logic ex_match;
  logic mem_match;

  // Register 0 is hardwired, so writes to it never create a dependency
  assign ex_match  = ex_we && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_match = mem_we && (mem_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));

  assign load_use  = ex_match && ex_load;
  assign raw_match = ex_match || mem_match;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller; HC_FORWARD_EN limits stalls to load-use
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH   = 5,
  parameter int MAX_WAIT = 8
) (
  input  logic              hc_clk,
  input  logic              hc_rst,
  input  logic              hc_i_ce,
  input  logic [AWIDTH-1:0] hc_i_id_rs1,
  input  logic [AWIDTH-1:0] hc_i_id_rs2,
  input  logic              hc_i_id_use_rs1,
  input  logic              hc_i_id_use_rs2,
  input  logic [AWIDTH-1:0] hc_i_ex_rd,
  input  logic              hc_i_ex_we,
  input  logic              hc_i_ex_load,
  input  logic [AWIDTH-1:0] hc_i_mem_rd,
  input  logic              hc_i_mem_we,
  input  logic              hc_i_branch_taken,
  input  logic              hc_i_mem_req,
  input  logic              hc_i_mem_ready,
  output logic              hc_o_stall_f,
  output logic              hc_o_stall_d,
  output logic              hc_o_flush_d,
  output logic              hc_o_flush_e,
  output logic              hc_o_ce_m,
  output logic              hc_o_mem_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          branch_pend, branch_pend_nxt;
  logic          mem_err, mem_err_nxt;
  logic          load_use, raw_match, stall_hz;
  logic          mem_wait;
  stage_ctrl_t   ctrl;

  hazard_detect #(
    .AWIDTH (AWIDTH)
  ) u_detect (
    .id_rs1     (hc_i_id_rs1),
    .id_rs2     (hc_i_id_rs2),
    .id_use_rs1 (hc_i_id_use_rs1),
    .id_use_rs2 (hc_i_id_use_rs2),
    .ex_rd      (hc_i_ex_rd),
    .ex_we      (hc_i_ex_we),
    .ex_load    (hc_i_ex_load),
    .mem_rd     (hc_i_mem_rd),
    .mem_we     (hc_i_mem_we),
    .load_use   (load_use),
    .raw_match  (raw_match)
  );

`ifdef HC_FORWARD_EN
  // EX/MEM results are forwarded; only a load in EX cannot be bypassed in time
  assign stall_hz = load_use;
`else
  // No bypass network: any pending write to a read source must drain first
  assign stall_hz = raw_match | load_use;
`endif

  assign mem_wait = hc_i_mem_req & ~hc_i_mem_ready;

  // Next-state, wait counter, pending-branch and timeout bookkeeping
  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    branch_pend_nxt = branch_pend;
    mem_err_nxt     = mem_err;
    if (hc_i_ce) begin
      case (state)
        ST_INIT: state_nxt = ST_RUN;
        ST_RUN: begin
          if (mem_wait) begin
            state_nxt    = ST_MWAIT;
            wait_cnt_nxt = '0;
          end else if (!hc_i_branch_taken && stall_hz) begin
            state_nxt = ST_LSTALL;
          end
        end
        ST_LSTALL: state_nxt = ST_RUN;
        ST_MWAIT: begin
          if (hc_i_mem_ready) begin
            state_nxt       = ST_RUN;
            wait_cnt_nxt    = '0;
            branch_pend_nxt = 1'b0;
          end else begin
            if (hc_i_branch_taken) begin
              branch_pend_nxt = 1'b1;
            end
            if (wait_cnt == CNT_MAX) begin
              state_nxt   = ST_HALT;
              mem_err_nxt = 1'b1;
            end else begin
              wait_cnt_nxt = wait_cnt + 1'b1;
            end
          end
        end
        ST_HALT: state_nxt = ST_HALT;
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  // State registers; reset discards pending branch, counter and error
  always_ff @(posedge hc_clk or negedge hc_rst) begin
    if (!hc_rst) begin
      state       <= ST_INIT;
      wait_cnt    <= '0;
      branch_pend <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      branch_pend <= branch_pend_nxt;
      mem_err     <= mem_err_nxt;
    end
  end

  // Stage controls from state and live inputs; reset is gated in so no glitch escapes
  always_comb begin
    ctrl = CTRL_RESET;
    if (!hc_rst) begin
      ctrl = CTRL_RESET;
    end else if (!hc_i_ce) begin
      ctrl = CTRL_HOLD;
    end else begin
      case (state)
        ST_INIT: ctrl = CTRL_RESET;
        ST_RUN: begin
          if (mem_wait) begin
            ctrl = CTRL_HOLD;
          end else if (hc_i_branch_taken) begin
            ctrl = CTRL_FLUSH;
          end else if (stall_hz) begin
            ctrl = CTRL_BUBBLE;
          end else begin
            ctrl = CTRL_RUN;
          end
        end
        ST_LSTALL: ctrl = CTRL_RUN;
        ST_MWAIT: begin
          if (hc_i_mem_ready) begin
            ctrl         = CTRL_RUN;
            ctrl.flush_d = branch_pend | hc_i_branch_taken;
            ctrl.flush_e = branch_pend | hc_i_branch_taken;
          end else begin
            ctrl = CTRL_HOLD;
          end
        end
        ST_HALT: ctrl = CTRL_HOLD;
        default: ctrl = CTRL_RESET;
      endcase
    end
  end

  assign hc_o_stall_f = ctrl.stall_f;
  assign hc_o_stall_d = ctrl.stall_d;
  assign hc_o_flush_d = ctrl.flush_d;
  assign hc_o_flush_e = ctrl.flush_e;
  assign hc_o_ce_m    = ctrl.ce_m;
  assign hc_o_mem_err = mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int MW = 4;

  logic          hc_clk = 1'b0;
  logic          hc_rst = 1'b0;
  logic          hc_i_ce = 1'b0;
  logic [AW-1:0] hc_i_id_rs1 = '0, hc_i_id_rs2 = '0;
  logic          hc_i_id_use_rs1 = 1'b0, hc_i_id_use_rs2 = 1'b0;
  logic [AW-1:0] hc_i_ex_rd = '0, hc_i_mem_rd = '0;
  logic          hc_i_ex_we = 1'b0, hc_i_ex_load = 1'b0, hc_i_mem_we = 1'b0;
  logic          hc_i_branch_taken = 1'b0, hc_i_mem_req = 1'b0, hc_i_mem_ready = 1'b0;
  logic          hc_o_stall_f, hc_o_stall_d, hc_o_flush_d, hc_o_flush_e, hc_o_ce_m, hc_o_mem_err;

  int tests = 0;
  int fails = 0;

  hazard_ctrl #(.AWIDTH(AW), .MAX_WAIT(MW)) dut (
    .hc_clk            (hc_clk),
    .hc_rst            (hc_rst),
    .hc_i_ce           (hc_i_ce),
    .hc_i_id_rs1       (hc_i_id_rs1),
    .hc_i_id_rs2       (hc_i_id_rs2),
    .hc_i_id_use_rs1   (hc_i_id_use_rs1),
    .hc_i_id_use_rs2   (hc_i_id_use_rs2),
    .hc_i_ex_rd        (hc_i_ex_rd),
    .hc_i_ex_we        (hc_i_ex_we),
    .hc_i_ex_load      (hc_i_ex_load),
    .hc_i_mem_rd       (hc_i_mem_rd),
    .hc_i_mem_we       (hc_i_mem_we),
    .hc_i_branch_taken (hc_i_branch_taken),
    .hc_i_mem_req      (hc_i_mem_req),
    .hc_i_mem_ready    (hc_i_mem_ready),
    .hc_o_stall_f      (hc_o_stall_f),
    .hc_o_stall_d      (hc_o_stall_d),
    .hc_o_flush_d      (hc_o_flush_d),
    .hc_o_flush_e      (hc_o_flush_e),
    .hc_o_ce_m         (hc_o_ce_m),
    .hc_o_mem_err      (hc_o_mem_err)
  );

  always #5 hc_clk = ~hc_clk;

  // Reference model: mode 0 init, 1 run, 2 after-hazard bubble, 3 memory wait, 4 halted
  int m_mode   = 0;
  int m_waited = 0;
  bit m_pend   = 0;
  bit m_err    = 0;

`ifdef HC_FORWARD_EN
  localparam logic [5:0] EXP_MEM_HZ = 6'b000001;
`else
  localparam logic [5:0] EXP_MEM_HZ = 6'b011011;
`endif

  function automatic bit m_hazard();
    bit reads_ex, reads_mem;
    reads_ex  = (hc_i_id_use_rs1 && hc_i_id_rs1 == hc_i_ex_rd) || (hc_i_id_use_rs2 && hc_i_id_rs2 == hc_i_ex_rd);
    reads_mem = (hc_i_id_use_rs1 && hc_i_id_rs1 == hc_i_mem_rd) || (hc_i_id_use_rs2 && hc_i_id_rs2 == hc_i_mem_rd);
    reads_ex  = reads_ex && hc_i_ex_we && (int'(hc_i_ex_rd) != 0);
    reads_mem = reads_mem && hc_i_mem_we && (int'(hc_i_mem_rd) != 0);
`ifdef HC_FORWARD_EN
    return reads_ex && hc_i_ex_load;
`else
    return reads_ex || reads_mem;
`endif
  endfunction

  // Expected {stall_f, stall_d, flush_d, flush_e, ce_m}
  function automatic logic [4:0] m_out();
    bit p;
    if (!hc_rst) return 5'b11110;
    if (!hc_i_ce) return 5'b11000;
    if (m_mode == 0) return 5'b11110;
    if (m_mode == 2) return 5'b00001;
    if (m_mode == 4) return 5'b11000;
    if (m_mode == 3) begin
      if (!hc_i_mem_ready) return 5'b11000;
      p = m_pend || hc_i_branch_taken;
      return {2'b00, p, p, 1'b1};
    end
    if (hc_i_mem_req && !hc_i_mem_ready) return 5'b11000;
    if (hc_i_branch_taken) return 5'b00111;
    if (m_hazard()) return 5'b11011;
    return 5'b00001;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_waited = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic m_clock();
    if (!hc_rst) begin
      m_reset();
    end else if (hc_i_ce) begin
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 2) m_mode = 1;
      else if (m_mode == 1) begin
        if (hc_i_mem_req && !hc_i_mem_ready) begin m_mode = 3; m_waited = 0; end
        else if (!hc_i_branch_taken && m_hazard()) m_mode = 2;
      end else if (m_mode == 3) begin
        if (hc_i_mem_ready) begin m_mode = 1; m_waited = 0; m_pend = 0; end
        else begin
          m_pend = m_pend || hc_i_branch_taken;
          if (m_waited >= MW) begin m_mode = 4; m_err = 1; end
          else m_waited++;
        end
      end
    end
  endtask

  function automatic logic [7:0] outs();
    return {2'b00, hc_o_mem_err, hc_o_stall_f, hc_o_stall_d, hc_o_flush_d, hc_o_flush_e, hc_o_ce_m};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Check one cycle (model, and optionally a fixed value), then advance to the next negedge
  task automatic step(input string tag, input bit use_c = 1'b0, input logic [5:0] c = 6'b0);
    if (!hc_rst) m_reset();
    #1;
    check(tag, outs(), {2'b00, m_err, m_out()});
    if (use_c) check({tag, "_const"}, outs(), {2'b00, c});
    @(posedge hc_clk);
    m_clock();
    @(negedge hc_clk);
  endtask

  task automatic clear_inputs();
    hc_i_ce = 1'b1;
    hc_i_id_rs1 = '0; hc_i_id_rs2 = '0; hc_i_id_use_rs1 = 1'b0; hc_i_id_use_rs2 = 1'b0;
    hc_i_ex_rd = '0; hc_i_ex_we = 1'b0; hc_i_ex_load = 1'b0;
    hc_i_mem_rd = '0; hc_i_mem_we = 1'b0;
    hc_i_branch_taken = 1'b0; hc_i_mem_req = 1'b0; hc_i_mem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    hc_rst = 1'b0;
    #2;
    step("rst_hold", 1, 6'b011110);
    hc_rst = 1'b1;
    step("init_cycle", 1, 6'b011110);
    step("run_idle", 1, 6'b000001);

    // Load-use hazard
    hc_i_ex_load = 1'b1; hc_i_ex_rd = 5'd5; hc_i_ex_we = 1'b1; hc_i_id_rs1 = 5'd5; hc_i_id_use_rs1 = 1'b1;
    step("lu_detect", 1, 6'b011011);
    clear_inputs();
    step("lu_bubble", 1, 6'b000001);
    step("lu_run", 1, 6'b000001);

    // Memory wait, ready on the fourth cycle
    hc_i_mem_req = 1'b1;
    for (int i = 0; i < 3; i++) step("mw_stall", 1, 6'b011000);
    hc_i_mem_ready = 1'b1;
    step("mw_ready", 1, 6'b000001);
    clear_inputs();
    step("mw_run", 1, 6'b000001);

    // Branch seen while waiting produces one flush pulse on exit
    hc_i_mem_req = 1'b1;
    step("br_req", 1, 6'b011000);
    hc_i_branch_taken = 1'b1;
    step("br_in_wait", 1, 6'b011000);
    hc_i_branch_taken = 1'b0;
    step("br_wait2", 1, 6'b011000);
    hc_i_mem_ready = 1'b1;
    step("br_exit_flush", 1, 6'b000111);
    clear_inputs();
    step("br_single_pulse", 1, 6'b000001);

    // Match against the memory stage
    hc_i_mem_rd = 5'd7; hc_i_mem_we = 1'b1; hc_i_id_rs2 = 5'd7; hc_i_id_use_rs2 = 1'b1;
    step("mem_stage_hz", 1, EXP_MEM_HZ);
    clear_inputs();
    step("mem_stage_after");
    step("mem_stage_idle", 1, 6'b000001);

    // Register zero never creates a hazard
    hc_i_ex_rd = '0; hc_i_ex_we = 1'b1; hc_i_ex_load = 1'b1; hc_i_id_rs1 = '0; hc_i_id_use_rs1 = 1'b1;
    step("rd_zero", 1, 6'b000001);

    // Branch outranks load-use
    hc_i_ex_rd = 5'd3; hc_i_id_rs1 = 5'd3; hc_i_branch_taken = 1'b1;
    step("br_over_lu", 1, 6'b000111);
    clear_inputs();

    // Pipeline enable low freezes and holds
    hc_i_ce = 1'b0; hc_i_mem_req = 1'b1;
    step("ce_freeze", 1, 6'b011000);
    clear_inputs();
    step("ce_resume", 1, 6'b000001);

    // Timeout into HALT with MAX_WAIT = 4
    hc_i_mem_req = 1'b1;
    for (int i = 0; i < 5; i++) step("to_wait", 1, 6'b011000);
    check("to_err_not_yet", {7'b0, hc_o_mem_err}, 8'd0);
    step("to_last_wait", 1, 6'b011000);
    check("to_err_set", {7'b0, hc_o_mem_err}, 8'd1);
    clear_inputs();
    for (int i = 0; i < 3; i++) step("halt_hold", 1, 6'b111000);

    // Asynchronous reset mid-cycle clears the error at once
    #2;
    hc_rst = 1'b0;
    #1;
    m_reset();
    check("rst_async", outs(), 8'b00011110);
    @(negedge hc_clk);
    step("rst_in_halt", 1, 6'b011110);
    hc_rst = 1'b1;
    step("post_rst_init", 1, 6'b011110);
    step("post_rst_run", 1, 6'b000001);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      hc_rst            = ($urandom_range(0, 99) >= 2);
      hc_i_ce           = ($urandom_range(0, 9) != 0);
      hc_i_id_rs1       = AW'($urandom_range(0, 3));
      hc_i_id_rs2       = AW'($urandom_range(0, 3));
      hc_i_id_use_rs1   = 1'($urandom_range(0, 1));
      hc_i_id_use_rs2   = 1'($urandom_range(0, 1));
      hc_i_ex_rd        = AW'($urandom_range(0, 3));
      hc_i_ex_we        = 1'($urandom_range(0, 1));
      hc_i_ex_load      = 1'($urandom_range(0, 1));
      hc_i_mem_rd       = AW'($urandom_range(0, 3));
      hc_i_mem_we       = 1'($urandom_range(0, 1));
      hc_i_branch_taken = ($urandom_range(0, 99) < 15);
      hc_i_mem_req      = ($urandom_range(0, 99) < 25);
      hc_i_mem_ready    = ($urandom_range(0, 99) < 45);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
